sample_apb_master: RTL and testbench
====================================

Name: sample_apb_master

Overview:
- Upstream stage of the generated register block: converts a simple valid/ready request/response interface from a local controller into APB4 master transactions.
- Its APB outputs connect to the register block's APB slave interface.
- Holds one outstanding transaction; buffers request and response so both sides may stall independently.

Parameters:
- ADDRESS_WIDTH, 8, width of request address and o_paddr.
- BUS_WIDTH, 32, data width; strobe width is BUS_WIDTH/8.
- PPROT_VALUE, 3'b000, constant driven on o_pprot.
- TIMEOUT_CYCLES, 64, ACCESS-phase cycle limit; used only with the optional feature; legal range 1..65535.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid&ready.
- i_req_write  in  1  1=write, 0=read.
- i_req_address  in  ADDRESS_WIDTH  byte address.
- i_req_write_data  in  BUS_WIDTH  write data.
- i_req_strobe  in  BUS_WIDTH/8  byte enables.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumed when valid&ready.
- o_rsp_read_data  out  BUS_WIDTH  read data; 0 for writes.
- o_rsp_error  out  1  PSLVERR (or timeout) of the transaction.
- o_psel, o_penable, o_pwrite  out  1 each  APB controls.
- o_paddr  out  ADDRESS_WIDTH  APB address.
- o_pprot  out  3  = PPROT_VALUE.
- o_pstrb  out  BUS_WIDTH/8  APB strobe.
- o_pwdata  out  BUS_WIDTH  APB write data.
- i_pready, i_pslverr  in  1 each.
- i_prdata  in  BUS_WIDTH.

Behaviour:
- Reset (asynchronous, active-high): FSM=IDLE; all outputs 0 except o_pprot=PPROT_VALUE. Asserting i_rst mid-transaction drops o_psel/o_penable and discards any pending response immediately.
- FSM states: IDLE, SETUP, ACCESS, RESPONSE.
- IDLE:
  - o_req_ready=1 (combinational from state only, not from i_req_valid).
  - On valid&ready: register write, address (low log2(BUS_WIDTH/8) bits forced 0), data and strobe, then go to SETUP.
- SETUP: o_psel=1, o_penable=0; unconditionally go to ACCESS next cycle.
- ACCESS:
  - o_psel=1, o_penable=1; hold while i_pready=0.
  - On i_pready=1: capture i_prdata (reads only; writes capture 0) and i_pslverr, then go to RESPONSE.
- RESPONSE:
  - o_rsp_valid=1, o_psel=0; data/error held stable until i_rsp_ready.
  - On handshake go to IDLE. No back-to-back bypass: a new request is accepted at the earliest the cycle after the response handshake.
- o_paddr, o_pwrite, o_pwdata and o_pstrb stay stable from SETUP through ACCESS completion.
- o_pstrb=0 for reads (APB4). o_pwdata=0 for reads.
- Minimum latency with pready=1 in the first ACCESS cycle:
  - request handshake at cycle N;
  - SETUP at N+1, ACCESS at N+2;
  - o_rsp_valid at N+3.
- Strobe 0 on a write: transfer is still issued.
- i_pslverr is sampled only when i_pready=1.

Optional Feature:
- Macro: SAMPLE_APB_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on SETUP entry and increments each ACCESS cycle with i_pready=0.
  - When the count reaches TIMEOUT_CYCLES, the transaction ends: o_psel/o_penable deassert, RESPONSE is entered with o_rsp_error=1 and o_rsp_read_data=0.
  - i_pready arriving in the same cycle as expiry wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is ignored.

Decomposition:
- Package sample_apb_master_pkg:
  - state enum type sample_apb_master_state_e (IDLE, SETUP, ACCESS, RESPONSE);
  - localparam function for strobe width;
  - timeout counter width constant (16).
- Sub-module sample_apb_timeout_counter: clear, enable, limit inputs; expired output. Instantiated only under the macro.

Test Plan:
- Write addr 8'h18, data 32'h1, strobe 4'hF, pready=1 immediately:
  - psel at N+1, penable at N+2, pwrite=1, paddr=8'h18, pstrb=4'hF;
  - rsp_valid at N+3 with error=0, read_data=0.
- Read addr 8'h04, pready delayed 3 cycles, prdata=32'h0F0F0F0F:
  - penable held 4 cycles, pstrb=0;
  - rsp read_data=32'h0F0F0F0F.
- Read addr 8'h07: paddr=8'h04.
- Read with pslverr=1 and rsp_ready low 5 cycles:
  - rsp_valid, error=1 and data stable for 5 cycles;
  - req_ready stays 0 until the cycle after the response handshake.
- Assert i_rst during ACCESS: psel/penable/rsp_valid go 0 without a clock edge; after release req_ready=1 and the next request completes normally.
- With SAMPLE_APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready held 0: transaction aborts after 4 ACCESS cycles with rsp error=1, data=0.
- Repeat with pready=1 on the 4th ACCESS cycle: normal response, error=0.

Source files
------------

// File: rtl/sample_apb_master_pkg.sv
// sample_apb_master_pkg: shared types and constants for the APB4 request master
package sample_apb_master_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} sample_apb_master_state_e;
  localparam int TIMEOUT_WIDTH = 16;
  function automatic int strobe_width(input int bus_width);
    return bus_width / 8;
  endfunction
endpackage

// File: rtl/sample_apb_timeout_counter.sv
// sample_apb_timeout_counter: counts stalled ACCESS cycles and flags the cycle the limit is reached
// Ports: i_clk, i_rst (async, active-high), i_clear (restart count), i_enable (stalled cycle),
//        i_limit (cycle limit), o_expired (this stalled cycle brings the count to i_limit)
module sample_apb_timeout_counter
  import sample_apb_master_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_enable,
  input  logic [TIMEOUT_WIDTH-1:0] i_limit,
  output logic                     o_expired
);
  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
  always_comb count_d = i_clear ? '0 : i_enable ? count_q + 1'b1 : count_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) count_q <= '0;
    else count_q <= count_d;
  // Expiry is flagged during the stalled cycle whose increment would reach the limit,
  // so the FSM leaves ACCESS at the same edge the count gets there.
  assign o_expired = i_enable && (count_q + 1'b1 >= i_limit);
endmodule

// File: rtl/sample_apb_master.sv
// sample_apb_master: valid/ready request/response to APB4 master bridge, one transaction outstanding
// Ports: i_clk, i_rst (async, active-high); request i_req_*/o_req_ready; response o_rsp_*/i_rsp_ready;
//        APB4 master o_psel/o_penable/o_pwrite/o_paddr/o_pprot/o_pstrb/o_pwdata, i_pready/i_pslverr/i_prdata.
// Optional: SAMPLE_APB_MASTER_TIMEOUT_EN aborts ACCESS with an error after TIMEOUT_CYCLES stalled cycles.
module sample_apb_master
  import sample_apb_master_pkg::*;
#(
  parameter int         ADDRESS_WIDTH  = 8,
  parameter int         BUS_WIDTH      = 32,
  parameter logic [2:0] PPROT_VALUE    = 3'b000,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_req_valid,
  output logic                                o_req_ready,
  input  logic                                i_req_write,
  input  logic [ADDRESS_WIDTH-1:0]            i_req_address,
  input  logic [BUS_WIDTH-1:0]                i_req_write_data,
  input  logic [strobe_width(BUS_WIDTH)-1:0]  i_req_strobe,
  output logic                                o_rsp_valid,
  input  logic                                i_rsp_ready,
  output logic [BUS_WIDTH-1:0]                o_rsp_read_data,
  output logic                                o_rsp_error,
  output logic                                o_psel,
  output logic                                o_penable,
  output logic                                o_pwrite,
  output logic [ADDRESS_WIDTH-1:0]            o_paddr,
  output logic [2:0]                          o_pprot,
  output logic [strobe_width(BUS_WIDTH)-1:0]  o_pstrb,
  output logic [BUS_WIDTH-1:0]                o_pwdata,
  input  logic                                i_pready,
  input  logic                                i_pslverr,
  input  logic [BUS_WIDTH-1:0]                i_prdata
);
  localparam int STRB_W = strobe_width(BUS_WIDTH);
  localparam int LSB = $clog2(STRB_W);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'((1 << LSB) - 1);
  sample_apb_master_state_e state_q, state_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]        strb_q, strb_d;
  logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic                     timeout;
`ifdef SAMPLE_APB_MASTER_TIMEOUT_EN
  sample_apb_timeout_counter u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (state_q == SETUP),
    .i_enable  (state_q == ACCESS && !i_pready),
    .i_limit   (TIMEOUT_WIDTH'(TIMEOUT_CYCLES)),
    .o_expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (i_req_valid) begin
        state_d = SETUP;
        write_d = i_req_write;
        addr_d  = i_req_address & ADDR_MASK;
        // Reads carry zero data and strobe on the bus.
        wdata_d = i_req_write ? i_req_write_data : '0;
        strb_d  = i_req_write ? i_req_strobe : '0;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (i_pready) begin
        state_d = RESPONSE;
        rdata_d = write_q ? '0 : i_prdata;
        err_d   = i_pslverr;
      end else if (timeout) begin
        state_d = RESPONSE;
        rdata_d = '0;
        err_d   = 1'b1;
      end
      RESPONSE: if (i_rsp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  // Ready is masked while reset is held so every output reads 0 during reset.
  assign o_req_ready     = state_q == IDLE && !i_rst;
  assign o_rsp_valid     = state_q == RESPONSE;
  assign o_rsp_read_data = rdata_q;
  assign o_rsp_error     = err_q;
  assign o_psel          = state_q == SETUP || state_q == ACCESS;
  assign o_penable       = state_q == ACCESS;
  assign o_pwrite        = write_q;
  assign o_paddr         = addr_q;
  assign o_pprot         = PPROT_VALUE;
  assign o_pstrb         = strb_q;
  assign o_pwdata        = wdata_q;
endmodule

// File: tb/tb_sample_apb_master.sv
// tb_sample_apb_master: self-checking bench for sample_apb_master with a transaction-level reference model
module tb_sample_apb_master;
  localparam int TO = 4;
  localparam logic [2:0] PPROT = 3'b101;
`ifdef SAMPLE_APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic i_clk = 0, i_rst = 0;
  logic i_req_valid = 0, i_req_write = 0, i_rsp_ready = 0, i_pready = 0, i_pslverr = 0;
  logic [7:0] i_req_address = 0;
  logic [31:0] i_req_write_data = 0, i_prdata = 0;
  logic [3:0] i_req_strobe = 0;
  logic o_req_ready, o_rsp_valid, o_rsp_error, o_psel, o_penable, o_pwrite;
  logic [31:0] o_rsp_read_data, o_pwdata;
  logic [7:0] o_paddr;
  logic [2:0] o_pprot;
  logic [3:0] o_pstrb;
  int n_tests = 0, n_fail = 0;
  int obs_lat, obs_setup, obs_access;
  logic [7:0] obs_paddr;
  logic [31:0] obs_pwdata, obs_rdata;
  logic [3:0] obs_pstrb;
  logic obs_pwrite, obs_err, obs_apb_unstable, obs_rsp_unstable, obs_ready_busy, obs_ready_after;

  sample_apb_master #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .PPROT_VALUE(PPROT), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_address(i_req_address), .i_req_write_data(i_req_write_data),
    .i_req_strobe(i_req_strobe), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_read_data(o_rsp_read_data), .o_rsp_error(o_rsp_error), .o_psel(o_psel),
    .o_penable(o_penable), .o_pwrite(o_pwrite), .o_paddr(o_paddr), .o_pprot(o_pprot),
    .o_pstrb(o_pstrb), .o_pwdata(o_pwdata), .i_pready(i_pready), .i_pslverr(i_pslverr),
    .i_prdata(i_prdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference model: the slave answers on ACCESS cycle pdly+1; with the timeout build it
  // gives up after TO stalled cycles unless the answer lands on that very cycle.
  function automatic int exp_access(input int pdly);
    return (TO_EN && pdly + 1 > TO) ? TO : pdly + 1;
  endfunction
  function automatic bit exp_timed_out(input int pdly);
    return TO_EN && pdly + 1 > TO;
  endfunction

  // Drives one full transaction and records what the DUT did; the tests judge the record.
  task automatic do_txn(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int pdly, input logic [31:0] prd, input logic perr, input int rdly);
    int k = 0, guard = 0;
    obs_setup = 0; obs_access = 0; obs_apb_unstable = 0; obs_rsp_unstable = 0;
    obs_ready_busy = 0; obs_ready_after = 0; obs_rdata = 'x; obs_err = 'x;
    obs_paddr = 'x; obs_pwdata = 'x; obs_pstrb = 'x; obs_pwrite = 'x;
    while (!o_req_ready && guard < 50) begin step(); guard++; end
    i_req_valid = 1; i_req_write = w; i_req_address = a; i_req_write_data = d; i_req_strobe = s;
    step();
    i_req_valid = 0; i_req_write = 1'($urandom); i_req_address = 8'($urandom);
    i_req_write_data = $urandom; i_req_strobe = 4'($urandom);
    obs_lat = 1;
    while (!o_rsp_valid && obs_lat < 200) begin
      if (o_req_ready) obs_ready_busy = 1;
      i_pready = 0; i_prdata = $urandom; i_pslverr = 1'($urandom);
      if (o_psel && !o_penable) begin
        obs_setup++;
        obs_paddr = o_paddr; obs_pwdata = o_pwdata; obs_pstrb = o_pstrb; obs_pwrite = o_pwrite;
      end
      if (o_psel && o_penable) begin
        k++; obs_access++;
        if (o_paddr !== obs_paddr || o_pwdata !== obs_pwdata || o_pstrb !== obs_pstrb || o_pwrite !== obs_pwrite)
          obs_apb_unstable = 1;
        if (k == pdly + 1) begin i_pready = 1; i_prdata = prd; i_pslverr = perr; end
      end
      step();
      obs_lat++;
    end
    i_pready = 0;
    if (!o_rsp_valid) return;
    obs_rdata = o_rsp_read_data; obs_err = o_rsp_error;
    for (int i = 0; i < rdly; i++) begin
      if (o_req_ready || o_psel) obs_ready_busy = 1;
      step();
      if (!o_rsp_valid || o_rsp_read_data !== obs_rdata || o_rsp_error !== obs_err) obs_rsp_unstable = 1;
    end
    if (o_req_ready) obs_ready_busy = 1;
    i_rsp_ready = 1;
    step();
    i_rsp_ready = 0;
    obs_ready_after = o_req_ready && !o_rsp_valid;
  endtask

  task automatic test_reset();
    i_rst = 1;
    #2;
    n_tests++; if ({o_psel, o_penable, o_rsp_valid, o_req_ready} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctrl: psel/penable/rsp_valid/req_ready=%b expected 0000", {o_psel, o_penable, o_rsp_valid, o_req_ready}); end
    n_tests++; if (o_pprot !== PPROT) begin n_fail++; $display("FAIL reset_pprot: got %b expected %b", o_pprot, PPROT); end
    n_tests++; if ({o_paddr, o_pwdata, o_pstrb, o_rsp_read_data, o_rsp_error, o_pwrite} !== '0) begin n_fail++;
      $display("FAIL reset_data: data outputs not all 0"); end
    step(); step();
    i_rst = 0;
    step();
    n_tests++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_req_ready); end
  endtask

  task automatic test_write_basic();
    do_txn(1, 8'h18, 32'h1, 4'hF, 0, 32'hDEAD_BEEF, 0, 0);
    n_tests++; if (obs_lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", obs_lat); end
    n_tests++; if (obs_setup !== 1 || obs_access !== 1) begin n_fail++;
      $display("FAIL wr_phases: setup %0d access %0d expected 1 1", obs_setup, obs_access); end
    n_tests++; if ({obs_pwrite, obs_paddr, obs_pstrb, obs_pwdata} !== {1'b1, 8'h18, 4'hF, 32'h1}) begin n_fail++;
      $display("FAIL wr_bus: pwrite %b paddr %h pstrb %h pwdata %h expected 1 18 f 1", obs_pwrite, obs_paddr, obs_pstrb, obs_pwdata); end
    n_tests++; if (obs_rdata !== 32'h0 || obs_err !== 1'b0) begin n_fail++;
      $display("FAIL wr_rsp: data %h err %b expected 0 0", obs_rdata, obs_err); end
    n_tests++; if (obs_ready_after !== 1'b1) begin n_fail++; $display("FAIL wr_ready_after: got %b expected 1", obs_ready_after); end
  endtask

  task automatic test_read_wait();
    do_txn(0, 8'h04, 32'h1234_5678, 4'hF, 3, 32'h0F0F_0F0F, 0, 0);
    n_tests++; if (obs_access !== 4 || obs_apb_unstable !== 1'b0) begin n_fail++;
      $display("FAIL rd_wait_access: cycles %0d unstable %b expected 4 0", obs_access, obs_apb_unstable); end
    n_tests++; if (obs_pstrb !== 4'h0 || obs_pwdata !== 32'h0 || obs_pwrite !== 1'b0) begin n_fail++;
      $display("FAIL rd_wait_bus: pstrb %h pwdata %h pwrite %b expected 0 0 0", obs_pstrb, obs_pwdata, obs_pwrite); end
    n_tests++; if (obs_rdata !== 32'h0F0F_0F0F || obs_err !== 1'b0) begin n_fail++;
      $display("FAIL rd_wait_rsp: data %h err %b expected 0f0f0f0f 0", obs_rdata, obs_err); end
    n_tests++; if (obs_lat !== 6) begin n_fail++; $display("FAIL rd_wait_latency: got %0d expected 6", obs_lat); end
  endtask

  task automatic test_unaligned();
    do_txn(0, 8'h07, 32'h0, 4'hF, 0, 32'hA5A5_5A5A, 0, 0);
    n_tests++; if (obs_paddr !== 8'h04) begin n_fail++; $display("FAIL unaligned_paddr: got %h expected 04", obs_paddr); end
  endtask

  task automatic test_error_stall();
    do_txn(0, 8'h20, 32'h0, 4'hF, 1, 32'h5555_AAAA, 1, 5);
    n_tests++; if (obs_err !== 1'b1 || obs_rdata !== 32'h5555_AAAA) begin n_fail++;
      $display("FAIL err_rsp: err %b data %h expected 1 5555aaaa", obs_err, obs_rdata); end
    n_tests++; if (obs_rsp_unstable !== 1'b0) begin n_fail++; $display("FAIL err_hold: response changed during stall"); end
    n_tests++; if (obs_ready_busy !== 1'b0 || obs_ready_after !== 1'b1) begin n_fail++;
      $display("FAIL err_req_ready: busy %b after %b expected 0 1", obs_ready_busy, obs_ready_after); end
  endtask

  task automatic test_strobe_zero();
    do_txn(1, 8'h3C, 32'hCAFE_F00D, 4'h0, 0, 32'h0, 0, 1);
    n_tests++; if (obs_setup !== 1 || obs_access !== 1 || obs_pwrite !== 1'b1 || obs_pstrb !== 4'h0 || obs_pwdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL strb0_issue: setup %0d access %0d pwrite %b pstrb %h pwdata %h expected 1 1 1 0 cafef00d",
        obs_setup, obs_access, obs_pwrite, obs_pstrb, obs_pwdata); end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (!o_req_ready && guard < 50) begin step(); guard++; end
    i_req_valid = 1; i_req_write = 0; i_req_address = 8'h10;
    step();
    i_req_valid = 0;
    step();
    n_tests++; if (o_penable !== 1'b1) begin n_fail++; $display("FAIL arst_access: penable %b expected 1", o_penable); end
    #3;
    i_rst = 1;
    #1;
    n_tests++; if ({o_psel, o_penable, o_rsp_valid, o_req_ready} !== 4'b0) begin n_fail++;
      $display("FAIL arst_drop: psel/penable/rsp_valid/req_ready=%b expected 0000", {o_psel, o_penable, o_rsp_valid, o_req_ready}); end
    step(); step();
    i_rst = 0;
    #1;
    n_tests++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b expected 1", o_req_ready); end
    do_txn(1, 8'h44, 32'h0BAD_CAFE, 4'h3, 0, 32'h0, 0, 0);
    n_tests++; if (obs_lat !== 3 || obs_err !== 1'b0 || obs_ready_after !== 1'b1) begin n_fail++;
      $display("FAIL arst_next: lat %0d err %b ready_after %b expected 3 0 1", obs_lat, obs_err, obs_ready_after); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      logic w = 1'($urandom);
      logic [7:0] a = 8'($urandom);
      logic [31:0] d = $urandom, prd = $urandom;
      logic [3:0] s = 4'($urandom);
      logic perr = 1'($urandom);
      int pdly = $urandom_range(0, 5), rdly = $urandom_range(0, 3);
      bit tmo = exp_timed_out(pdly);
      logic [31:0] e_rdata = (w || tmo) ? 32'h0 : prd;
      logic e_err = tmo ? 1'b1 : perr;
      do_txn(w, a, d, s, pdly, prd, perr, rdly);
      n_tests++; if (obs_lat !== 2 + exp_access(pdly) || obs_access !== exp_access(pdly)) begin n_fail++;
        $display("FAIL rand_timing[%0d]: lat %0d access %0d expected %0d %0d", t, obs_lat, obs_access, 2 + exp_access(pdly), exp_access(pdly)); end
      n_tests++; if ({obs_pwrite, obs_paddr, obs_pstrb, obs_pwdata} !== {w, a & 8'hFC, w ? s : 4'h0, w ? d : 32'h0}) begin n_fail++;
        $display("FAIL rand_bus[%0d]: pwrite %b paddr %h pstrb %h pwdata %h expected %b %h %h %h", t, obs_pwrite, obs_paddr,
          obs_pstrb, obs_pwdata, w, a & 8'hFC, w ? s : 4'h0, w ? d : 32'h0); end
      n_tests++; if (obs_rdata !== e_rdata || obs_err !== e_err) begin n_fail++;
        $display("FAIL rand_rsp[%0d]: data %h err %b expected %h %b", t, obs_rdata, obs_err, e_rdata, e_err); end
      n_tests++; if (obs_apb_unstable || obs_rsp_unstable || obs_ready_busy || !obs_ready_after) begin n_fail++;
        $display("FAIL rand_protocol[%0d]: apb_unstable %b rsp_unstable %b ready_busy %b ready_after %b expected 0 0 0 1",
          t, obs_apb_unstable, obs_rsp_unstable, obs_ready_busy, obs_ready_after); end
    end
  endtask

`ifdef SAMPLE_APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    do_txn(0, 8'h08, 32'h0, 4'hF, 50, 32'hFFFF_FFFF, 0, 2);
    n_tests++; if (obs_access !== TO || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin n_fail++;
      $display("FAIL timeout_abort: access %0d err %b data %h expected %0d 1 0", obs_access, obs_err, obs_rdata, TO); end
    do_txn(0, 8'h08, 32'h0, 4'hF, TO - 1, 32'h1357_9BDF, 0, 0);
    n_tests++; if (obs_access !== TO || obs_err !== 1'b0 || obs_rdata !== 32'h1357_9BDF) begin n_fail++;
      $display("FAIL timeout_race: access %0d err %b data %h expected %0d 0 13579bdf", obs_access, obs_err, obs_rdata, TO); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_unaligned();
    test_error_stall();
    test_strobe_zero();
    test_async_reset();
`ifdef SAMPLE_APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
